// File: rtl/bus_host_arb.sv
// Round-robin arbiter sharing one downstream req/gnt/rvalid bus port between NrHosts requesters.
// Responses are steered back in order through a small FIFO of granted host IDs.
module bus_host_arb #(
   parameter int NrHosts        = 2,
   parameter int AddrWidth      = 32,
   parameter int DataWidth      = 32,
   parameter int MaxOutstanding = 2
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NrHosts-1:0]                    host_req_i,
   output logic [NrHosts-1:0]                    host_gnt_o,
   input  logic [AddrWidth-1:0]                  host_addr_i  [NrHosts],
   input  logic [NrHosts-1:0]                    host_we_i,
   input  logic [DataWidth/8-1:0]                host_be_i    [NrHosts],
   input  logic [DataWidth-1:0]                  host_wdata_i [NrHosts],
   output logic [NrHosts-1:0]                    host_rvalid_o,
   output logic [DataWidth-1:0]                  host_rdata_o [NrHosts],
   output logic [NrHosts-1:0]                    host_err_o,
   output logic                                  dev_req_o,
   input  logic                                  dev_gnt_i,
   output logic [AddrWidth-1:0]                  dev_addr_o,
   output logic                                  dev_we_o,
   output logic [DataWidth/8-1:0]                dev_be_o,
   output logic [DataWidth-1:0]                  dev_wdata_o,
   input  logic                                  dev_rvalid_i,
   input  logic [DataWidth-1:0]                  dev_rdata_i,
   input  logic                                  dev_err_i,
   output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
   output logic                                  spurious_o
);

   localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW = $clog2(MaxOutstanding+1);

   logic [IdxW-1:0] prio_q;
   logic [IdxW-1:0] winner;
   logic            any_req;
   logic [31:0]     cand;

   logic [IdxW-1:0] fifo_q [MaxOutstanding];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            full, accept, pop;
   logic [IdxW-1:0] head;

   // Winner search starts at the priority pointer and wraps, giving round-robin fairness.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      cand    = '0;
      for (int i = 0; i < NrHosts; i++) begin
         cand = (32'(prio_q) + 32'(i)) % 32'(NrHosts);
         if (!any_req && host_req_i[cand]) begin
            winner  = IdxW'(cand);
            any_req = 1'b1;
         end
      end
   end

   // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
   assign full      = (count_q == CntW'(MaxOutstanding));
   assign dev_req_o = rst_ni & any_req & ~full;
   assign accept    = dev_req_o & dev_gnt_i;
   assign head      = fifo_q[rd_ptr_q];
   assign pop       = dev_rvalid_i & (count_q != '0);
   assign spurious_o    = rst_ni & dev_rvalid_i & (count_q == '0);
   assign outstanding_o = count_q;

   always_comb begin
      dev_addr_o  = '0;
      dev_we_o    = 1'b0;
      dev_be_o    = '0;
      dev_wdata_o = '0;
      host_gnt_o  = '0;
      if (any_req) begin
         dev_addr_o  = host_addr_i[winner];
         dev_we_o    = host_we_i[winner];
         dev_be_o    = host_be_i[winner];
         dev_wdata_o = host_wdata_i[winner];
      end
      if (accept) host_gnt_o[winner] = 1'b1;
   end

   always_comb begin
      host_rvalid_o = '0;
      host_err_o    = '0;
      for (int i = 0; i < NrHosts; i++) host_rdata_o[i] = dev_rdata_i;
      if (pop) begin
         host_rvalid_o[head] = 1'b1;
         host_err_o[head]    = dev_err_i;
      end
   end

   // ID storage needs no reset; only the pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (accept) fifo_q[wr_ptr_q] <= winner;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (accept) begin
            prio_q   <= (winner == IdxW'(NrHosts-1)) ? '0 : winner + 1'b1;
            wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding-1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding-1)) ? '0 : rd_ptr_q + 1'b1;
         end
         if (accept && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !accept) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_host_arb.sv
// Directed self-checking bench for bus_host_arb with two hosts and two outstanding slots.
module tb_bus_host_arb;

   logic        clk_i;
   logic        rst_ni;
   logic [1:0]  host_req;
   logic [1:0]  host_gnt;
   logic [31:0] host_addr  [2];
   logic [1:0]  host_we;
   logic [3:0]  host_be    [2];
   logic [31:0] host_wdata [2];
   logic [1:0]  host_rvalid;
   logic [31:0] host_rdata [2];
   logic [1:0]  host_err;
   logic        dev_req, dev_gnt, dev_we, dev_rvalid, dev_err, spurious;
   logic [31:0] dev_addr, dev_wdata, dev_rdata;
   logic [3:0]  dev_be;
   logic [1:0]  outstanding;

   int testsRun = 0;
   int testsFailed = 0;

   bus_host_arb dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .host_req_i   (host_req),
      .host_gnt_o   (host_gnt),
      .host_addr_i  (host_addr),
      .host_we_i    (host_we),
      .host_be_i    (host_be),
      .host_wdata_i (host_wdata),
      .host_rvalid_o(host_rvalid),
      .host_rdata_o (host_rdata),
      .host_err_o   (host_err),
      .dev_req_o    (dev_req),
      .dev_gnt_i    (dev_gnt),
      .dev_addr_o   (dev_addr),
      .dev_we_o     (dev_we),
      .dev_be_o     (dev_be),
      .dev_wdata_o  (dev_wdata),
      .dev_rvalid_i (dev_rvalid),
      .dev_rdata_i  (dev_rdata),
      .dev_err_i    (dev_err),
      .outstanding_o(outstanding),
      .spurious_o   (spurious)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs at the falling edge; outputs are checked 1ns later.
   task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rvalid,
                                input logic err, input logic [31:0] rdata);
      @(negedge clk_i);
      host_req   = req;
      dev_gnt    = gnt;
      dev_rvalid = rvalid;
      dev_err    = err;
      dev_rdata  = rdata;
      #1;
   endtask

   logic [1:0] fairGnt [4];
   logic [1:0] fairRv  [4];

   initial begin
      rst_ni     = 1'b0;
      host_req   = '0;
      host_we    = 2'b10;
      host_addr[0]  = 32'h0010_0000;  host_addr[1]  = 32'hA000_0004;
      host_be[0]    = 4'h3;           host_be[1]    = 4'hF;
      host_wdata[0] = 32'h0;          host_wdata[1] = 32'h1234_5678;
      dev_gnt = 0; dev_rvalid = 0; dev_err = 0; dev_rdata = '0;
      fairGnt[0] = 2'b10; fairGnt[1] = 2'b01; fairGnt[2] = 2'b10; fairGnt[3] = 2'b01;
      fairRv[0]  = 2'b00; fairRv[1]  = 2'b10; fairRv[2]  = 2'b01; fairRv[3]  = 2'b10;

      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("rst_outstanding", outstanding, 0);
      checkOutput("rst_dev_req", dev_req, 0);
      checkOutput("rst_gnt", host_gnt, 0);
      checkOutput("rst_rvalid", host_rvalid, 0);
      checkOutput("rst_spurious", spurious, 0);
      checkOutput("idle_dev_addr", dev_addr, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Single host read
      applyStimulus(2'b01, 1, 0, 0, 32'h0);
      checkOutput("single_gnt", host_gnt, 2'b01);
      checkOutput("single_dev_req", dev_req, 1);
      checkOutput("single_addr", dev_addr, 32'h0010_0000);
      checkOutput("single_we", dev_we, 0);
      applyStimulus(2'b00, 0, 1, 0, 32'hDEAD_BEEF);
      checkOutput("single_out1", outstanding, 1);
      checkOutput("single_rvalid", host_rvalid, 2'b01);
      checkOutput("single_rdata", host_rdata[0], 32'hDEAD_BEEF);
      checkOutput("single_rdata_bcast", host_rdata[1], 32'hDEAD_BEEF);
      applyStimulus(2'b00, 0, 0, 0, 32'h0);
      checkOutput("single_out0", outstanding, 0);

      // Fairness: pointer sits at host1 after the single read
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b11, 1, (i != 0), 0, 32'h0);
         checkOutput($sformatf("fair_gnt%0d", i), host_gnt, fairGnt[i]);
         checkOutput($sformatf("fair_rv%0d", i), host_rvalid, fairRv[i]);
      end
      applyStimulus(2'b00, 0, 1, 0, 32'h0);
      checkOutput("fair_drain_rv", host_rvalid, 2'b01);
      checkOutput("fair_drain_out", outstanding, 1);

      // Full back-pressure with responses withheld
      applyStimulus(2'b11, 1, 0, 0, 32'h0);
      checkOutput("full_gnt_a", host_gnt, 2'b10);
      checkOutput("full_wdata", dev_wdata, 32'h1234_5678);
      checkOutput("full_be", dev_be, 4'hF);
      applyStimulus(2'b11, 1, 0, 0, 32'h0);
      checkOutput("full_gnt_b", host_gnt, 2'b01);
      applyStimulus(2'b11, 1, 0, 0, 32'h0);
      checkOutput("full_out2", outstanding, 2);
      checkOutput("full_dev_req", dev_req, 0);
      checkOutput("full_gnt_none", host_gnt, 2'b00);
      applyStimulus(2'b11, 1, 1, 0, 32'h0);
      checkOutput("full_pop_no_accept", dev_req, 0);
      checkOutput("full_pop_rv", host_rvalid, 2'b10);
      applyStimulus(2'b11, 1, 0, 0, 32'h0);
      checkOutput("full_reaccept_out", outstanding, 1);
      checkOutput("full_reaccept_gnt", host_gnt, 2'b10);
      applyStimulus(2'b00, 0, 1, 0, 32'h0);
      checkOutput("full_drain_rv0", host_rvalid, 2'b01);
      applyStimulus(2'b00, 0, 1, 0, 32'h0);
      checkOutput("full_drain_rv1", host_rvalid, 2'b10);
      applyStimulus(2'b00, 0, 0, 0, 32'h0);
      checkOutput("full_drain_out", outstanding, 0);

      // Routing with errors: host1 then host0
      applyStimulus(2'b10, 1, 0, 0, 32'h0);
      checkOutput("route_gnt1", host_gnt, 2'b10);
      checkOutput("route_addr1", dev_addr, 32'hA000_0004);
      checkOutput("route_we1", dev_we, 1);
      applyStimulus(2'b01, 1, 0, 0, 32'h0);
      checkOutput("route_gnt0", host_gnt, 2'b01);
      checkOutput("route_be0", dev_be, 4'h3);
      applyStimulus(2'b00, 0, 1, 1, 32'h0000_0011);
      checkOutput("route_rv1", host_rvalid, 2'b10);
      checkOutput("route_err1", host_err, 2'b10);
      applyStimulus(2'b00, 0, 1, 0, 32'h0000_0022);
      checkOutput("route_rv0", host_rvalid, 2'b01);
      checkOutput("route_err0", host_err, 2'b00);

      // Simultaneous push and pop at count 1
      applyStimulus(2'b01, 1, 0, 0, 32'h0);
      checkOutput("sim_gnt0", host_gnt, 2'b01);
      applyStimulus(2'b10, 1, 1, 0, 32'h0);
      checkOutput("sim_gnt1", host_gnt, 2'b10);
      checkOutput("sim_rv_old", host_rvalid, 2'b01);
      applyStimulus(2'b00, 0, 1, 0, 32'h0);
      checkOutput("sim_out1", outstanding, 1);
      checkOutput("sim_rv_new", host_rvalid, 2'b10);

      // Spurious response at count 0
      applyStimulus(2'b00, 0, 1, 0, 32'h0);
      checkOutput("spur_pulse", spurious, 1);
      checkOutput("spur_no_rv", host_rvalid, 2'b00);
      applyStimulus(2'b00, 0, 0, 0, 32'h0);
      checkOutput("spur_clear", spurious, 0);
      checkOutput("spur_out", outstanding, 0);

      // Reset with two transactions outstanding
      applyStimulus(2'b11, 1, 0, 0, 32'h0);
      applyStimulus(2'b11, 1, 0, 0, 32'h0);
      applyStimulus(2'b00, 0, 0, 0, 32'h0);
      checkOutput("rst_mid_out2", outstanding, 2);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      checkOutput("rst_mid_out0", outstanding, 0);
      checkOutput("rst_mid_dev_req", dev_req, 0);
      applyStimulus(2'b00, 0, 0, 0, 32'h0);
      rst_ni = 1'b1;
      applyStimulus(2'b00, 0, 1, 0, 32'h0);
      checkOutput("rst_late_spur", spurious, 1);
      checkOutput("rst_late_no_rv", host_rvalid, 2'b00);
      applyStimulus(2'b11, 1, 0, 0, 32'h0);
      checkOutput("rst_prio0_gnt", host_gnt, 2'b01);
      applyStimulus(2'b00, 0, 0, 0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
